// File: rtl/alu.sv
// Single-cycle MIPS-style ALU with HI/LO next-state outputs; one ALU-clock edge of latency.
// No handshake: every edge captures the current inputs; EXE clocks it from the inverted system clock.
module alu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALU_control,
  input  logic [4:0]  shiftAmount,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  output logic [31:0] aluResult,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT
);

  localparam logic [5:0] OP_ADD   = 6'b000010;
  localparam logic [5:0] OP_ADDU  = 6'b000011;
  localparam logic [5:0] OP_SUB   = 6'b000100;
  localparam logic [5:0] OP_SUBU  = 6'b000101;
  localparam logic [5:0] OP_AND   = 6'b000110;
  localparam logic [5:0] OP_OR    = 6'b000111;
  localparam logic [5:0] OP_XOR   = 6'b001000;
  localparam logic [5:0] OP_NOR   = 6'b001001;
  localparam logic [5:0] OP_SLT   = 6'b001010;
  localparam logic [5:0] OP_SLTU  = 6'b001011;
  localparam logic [5:0] OP_SLL   = 6'b001100;
  localparam logic [5:0] OP_SRL   = 6'b001101;
  localparam logic [5:0] OP_SRA   = 6'b001110;
  localparam logic [5:0] OP_SLLV  = 6'b001111;
  localparam logic [5:0] OP_SRLV  = 6'b010000;
  localparam logic [5:0] OP_SRAV  = 6'b010001;
  localparam logic [5:0] OP_LUI   = 6'b010010;
  localparam logic [5:0] OP_MULT  = 6'b010011;
  localparam logic [5:0] OP_MULTU = 6'b010100;
  localparam logic [5:0] OP_DIV   = 6'b010101;
  localparam logic [5:0] OP_DIVU  = 6'b010110;
  localparam logic [5:0] OP_MFHI  = 6'b010111;
  localparam logic [5:0] OP_MFLO  = 6'b011000;
  localparam logic [5:0] OP_MTHI  = 6'b011001;
  localparam logic [5:0] OP_MTLO  = 6'b011010;
  localparam logic [5:0] OP_PASSA = 6'b011011;
  localparam logic [5:0] OP_PASSB = 6'b011100;

  logic [31:0]        w_result;
  logic [31:0]        w_hi;
  logic [31:0]        w_lo;
  logic [63:0]        w_mul_s;
  logic [63:0]        w_mul_u;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;
  logic               w_div_zero;
  logic               w_div_ovf;

  // Low 64 bits of a product of sign-extended operands is the signed product.
  assign w_mul_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_mul_u    = {32'h0, A} * {32'h0, B};
  assign w_div_zero = (B == 32'h0);
  assign w_div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_quot_s   = $signed(A) / $signed(B);
  assign w_rem_s    = $signed(A) % $signed(B);
  assign w_quot_u   = A / B;
  assign w_rem_u    = A % B;

  always_comb begin
    w_result = 32'h0;
    w_hi     = HI_IN;
    w_lo     = LO_IN;
    case (ALU_control)
      OP_ADD, OP_ADDU: w_result = A + B;
      OP_SUB, OP_SUBU: w_result = A - B;
      OP_AND:   w_result = A & B;
      OP_OR:    w_result = A | B;
      OP_XOR:   w_result = A ^ B;
      OP_NOR:   w_result = ~(A | B);
      OP_SLT:   w_result = {31'h0, $signed(A) < $signed(B)};
      OP_SLTU:  w_result = {31'h0, A < B};
      OP_SLL:   w_result = B << shiftAmount;
      OP_SRL:   w_result = B >> shiftAmount;
      OP_SRA:   w_result = $signed(B) >>> shiftAmount;
      OP_SLLV:  w_result = B << A[4:0];
      OP_SRLV:  w_result = B >> A[4:0];
      OP_SRAV:  w_result = $signed(B) >>> A[4:0];
      OP_LUI:   w_result = {B[15:0], 16'h0};
      OP_PASSA: w_result = A;
      OP_PASSB: w_result = B;
      OP_MFHI:  w_result = HI_IN;
      OP_MFLO:  w_result = LO_IN;
      OP_MULT: begin
        w_hi = w_mul_s[63:32];
        w_lo = w_mul_s[31:0];
      end
      OP_MULTU: begin
        w_hi = w_mul_u[63:32];
        w_lo = w_mul_u[31:0];
      end
      // Divide-by-zero and MIN/-1 get fixed results rather than relying on simulator behaviour.
      OP_DIV: begin
        if (w_div_zero) begin
          w_hi = A;
          w_lo = 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
          w_hi = 32'h0;
          w_lo = 32'h8000_0000;
        end else begin
          w_hi = w_rem_s;
          w_lo = w_quot_s;
        end
      end
      OP_DIVU: begin
        if (w_div_zero) begin
          w_hi = A;
          w_lo = 32'hFFFF_FFFF;
        end else begin
          w_hi = w_rem_u;
          w_lo = w_quot_u;
        end
      end
      OP_MTHI:  w_hi = A;
      OP_MTLO:  w_lo = A;
      default:  w_result = 32'h0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      aluResult <= 32'h0;
      HI_OUT    <= 32'h0;
      LO_OUT    <= 32'h0;
    end else begin
      aluResult <= w_result;
      HI_OUT    <= w_hi;
      LO_OUT    <= w_lo;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: each step drives one operation, clocks once and checks all three outputs.
module tb_alu;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALU_control;
  logic [4:0]  shiftAmount;
  logic [31:0] HI_IN;
  logic [31:0] LO_IN;
  logic [31:0] aluResult;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  int checks   = 0;
  int failures = 0;

  alu dut (
    .CLK(CLK),
    .RESET(RESET),
    .A(A),
    .B(B),
    .ALU_control(ALU_control),
    .shiftAmount(shiftAmount),
    .HI_IN(HI_IN),
    .LO_IN(LO_IN),
    .aluResult(aluResult),
    .HI_OUT(HI_OUT),
    .LO_OUT(LO_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input logic [31:0] hi,
                      input logic [31:0] lo, input logic [31:0] exp_res,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    ALU_control = op;
    A           = a;
    B           = b;
    shiftAmount = sh;
    HI_IN       = hi;
    LO_IN       = lo;
    @(posedge CLK);
    #1;
    check({tag, ".res"}, aluResult, exp_res);
    check({tag, ".hi"}, HI_OUT, exp_hi);
    check({tag, ".lo"}, LO_OUT, exp_lo);
  endtask

  initial begin
    RESET       = 1'b1;
    A           = 32'd5;
    B           = 32'd3;
    ALU_control = 6'b000010;
    shiftAmount = 5'd0;
    HI_IN       = 32'h1111_1111;
    LO_IN       = 32'h2222_2222;
    repeat (3) @(posedge CLK);
    #1;
    check("reset.res", aluResult, 32'h0);
    check("reset.hi", HI_OUT, 32'h0);
    check("reset.lo", LO_OUT, 32'h0);
    RESET = 1'b0;
    HI_IN = 32'h0;
    LO_IN = 32'h0;
    @(posedge CLK);
    #1;
    check("first_add", aluResult, 32'd8);

    // Asynchronous reset mid-operation, asserted away from any clock edge.
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst.res", aluResult, 32'h0);
    #1;
    RESET = 1'b0;

    step("add_wrap", 6'b000010, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
    step("sub",      6'b000100, 32'd3, 32'd5, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h0);
    step("slt",      6'b001010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0);
    step("sltu",     6'b001011, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step("nor",      6'b001001, 32'hF0F0_0000, 32'h0000_00FF, 5'd0, 32'h0, 32'h0, 32'h0F0F_FF00, 32'h0, 32'h0);
    step("xor",      6'b001000, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'h0, 32'h0, 32'hF0F0_F0F0, 32'h0, 32'h0);
    step("sra",      6'b001110, 32'h0, 32'h8000_0000, 5'd4, 32'h0, 32'h0, 32'hF800_0000, 32'h0, 32'h0);
    step("srl",      6'b001101, 32'h0, 32'h8000_0000, 5'd4, 32'h0, 32'h0, 32'h0800_0000, 32'h0, 32'h0);
    step("sll",      6'b001100, 32'h0, 32'h0000_0003, 5'd31, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
    step("sllv",     6'b001111, 32'd33, 32'h1, 5'd7, 32'h0, 32'h0, 32'h2, 32'h0, 32'h0);
    step("srav",     6'b010001, 32'd8, 32'h8000_0000, 5'd0, 32'h0, 32'h0, 32'hFF80_0000, 32'h0, 32'h0);
    step("lui",      6'b010010, 32'h0, 32'h0000_1234, 5'd0, 32'h0, 32'h0, 32'h1234_0000, 32'h0, 32'h0);
    step("passa",    6'b011011, 32'hDEAD_BEEF, 32'h1, 5'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    step("mult",     6'b010011, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    step("multu",    6'b010100, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFE);
    step("div",      6'b010101, 32'hFFFF_FFF9, 32'h2, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step("divu0",    6'b010110, 32'd7, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'd7, 32'hFFFF_FFFF);
    step("div0",     6'b010101, 32'hFFFF_FFFB, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    step("div_ovf",  6'b010101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000);
    step("divu",     6'b010110, 32'd100, 32'd7, 5'd0, 32'h0, 32'h0, 32'h0, 32'd2, 32'd14);
    step("mthi",     6'b011001, 32'hAB, 32'h0, 5'd0, 32'h99, 32'h12, 32'h0, 32'hAB, 32'h12);
    step("mtlo",     6'b011010, 32'hCD, 32'h0, 5'd0, 32'h77, 32'h12, 32'h0, 32'h77, 32'hCD);
    step("mflo",     6'b011000, 32'h0, 32'h0, 5'd0, 32'h34, 32'h12, 32'h12, 32'h34, 32'h12);
    step("mfhi",     6'b010111, 32'h0, 32'h0, 5'd0, 32'h34, 32'h12, 32'h34, 32'h34, 32'h12);
    step("and_pass", 6'b000110, 32'hF0, 32'h3C, 5'd0, 32'h55, 32'h66, 32'h30, 32'h55, 32'h66);
    step("unlisted", 6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h55, 32'h66, 32'h0, 32'h55, 32'h66);
    step("op_zero",  6'h00, 32'h5, 32'h3, 5'd0, 32'hA1, 32'hB2, 32'h0, 32'hA1, 32'hB2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
